// File: rtl/control_unit_pkg.sv
// Shared types and constants for the control unit: FSM states, instruction
// classes, ALU operations and instruction field positions.
package control_unit_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;

  localparam int CLASS_MSB = 15;
  localparam int CLASS_LSB = 13;
  localparam int OP_MSB    = 12;
  localparam int OP_LSB    = 10;
  localparam int REG_MSB   = 9;
  localparam int REG_LSB   = 8;
  localparam int IMM_MSB   = 7;
  localparam int IMM_LSB   = 0;

  localparam logic [2:0] RF_CE_NONE = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_MEM    = 3'd3,
    ST_EXEC   = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP    = 3'b000,
    CLS_ALU_RF = 3'b001,
    CLS_ALU_DM = 3'b010,
    CLS_LDI    = 3'b011,
    CLS_ST     = 3'b100,
    CLS_JMP    = 3'b101,
    CLS_JZ     = 3'b110,
    CLS_HALT   = 3'b111
  } instr_class_e;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_NOT  = 3'b101,
    ALU_LD   = 3'b110,
    ALU_PASS = 3'b111
  } alu_op_e;

  function automatic instr_class_e instr_class(input logic [INSTR_W-1:0] instr);
    return instr_class_e'(instr[CLASS_MSB:CLASS_LSB]);
  endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational split of an instruction word into class, ALU op, register
// select and immediate/address fields.
module cu_decoder
  import control_unit_pkg::*;
(
  input  logic [INSTR_W-1:0] i_ir,
  output instr_class_e       o_class,
  output alu_op_e            o_alu_op,
  output logic [1:0]         o_reg,
  output logic [ADDR_W-1:0]  o_imm
);

  assign o_class  = instr_class(i_ir);
  assign o_alu_op = alu_op_e'(i_ir[OP_MSB:OP_LSB]);
  assign o_reg    = i_ir[REG_MSB:REG_LSB];
  assign o_imm    = i_ir[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: FETCH/DECODE/(MEM)/EXEC sequencer with program
// counter and instruction register; datapath controls are Moore outputs.
module control_unit
  import control_unit_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [15:0]         i_instr,
  input  logic [7:0]          i_acumulator,
  output logic [7:0]          o_instr_addr,
  output logic [7:0]          o_data_memory_addr,
  output logic [2:0]          o_operation_code,
  output logic                o_acumulator_ce,
  output logic [2:0]          o_register_file_ce,
  output logic [1:0]          o_register_file_mux_addr,
  output logic                o_data_memory_read_enable,
  output logic [7:0]          o_direct_data,
  output logic                o_direct_load,
  output logic                o_busy,
  output logic                o_halted
);

  state_e              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [INSTR_W-1:0]  r_ir;

  instr_class_e        w_class;
  alu_op_e             w_alu_op;
  logic [1:0]          w_reg;
  logic [ADDR_W-1:0]   w_imm;

  alu_op_e             w_op_code;
  logic                w_acc_ce;
  logic [2:0]          w_rf_ce;
  logic                w_dm_rd_en;
  logic                w_direct_load;

  cu_decoder u_decoder (
    .i_ir     (r_ir),
    .o_class  (w_class),
    .o_alu_op (w_alu_op),
    .o_reg    (w_reg),
    .o_imm    (w_imm)
  );

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_HALT: begin
          if (i_start) begin
            r_pc    <= '0;
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: r_state <= ST_DECODE;
        ST_DECODE: begin
          // The IR is not loaded yet, so branch on the class of the fetched word.
          r_ir    <= i_instr;
          r_pc    <= r_pc + 8'd1;
          r_state <= (instr_class(i_instr) == CLS_ALU_DM) ? ST_MEM : ST_EXEC;
        end
        ST_MEM: r_state <= ST_EXEC;
        ST_EXEC: begin
          if (w_class == CLS_JMP) begin
            r_pc <= w_imm;
          end else if (w_class == CLS_JZ && i_acumulator == 8'h00) begin
            r_pc <= w_imm;
          end
          r_state <= (w_class == CLS_HALT) ? ST_HALT : ST_FETCH;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    w_op_code     = ALU_LD;
    w_acc_ce      = 1'b0;
    w_rf_ce       = RF_CE_NONE;
    w_dm_rd_en    = 1'b0;
    w_direct_load = 1'b0;
    if (r_state == ST_EXEC) begin
      case (w_class)
        CLS_ALU_RF: begin
          w_op_code = w_alu_op;
          w_acc_ce  = 1'b1;
        end
        CLS_ALU_DM: begin
          w_op_code  = w_alu_op;
          w_acc_ce   = 1'b1;
          w_dm_rd_en = 1'b1;
        end
        CLS_LDI: begin
          w_acc_ce      = 1'b1;
          w_direct_load = 1'b1;
        end
        CLS_ST:  w_rf_ce = {1'b0, w_reg};
        default: ;
      endcase
    end
  end

  assign o_instr_addr              = r_pc;
  assign o_data_memory_addr        = w_imm;
  assign o_direct_data             = w_imm;
  assign o_register_file_mux_addr  = w_reg;
  assign o_operation_code          = w_op_code;
  assign o_acumulator_ce           = w_acc_ce;
  assign o_register_file_ce        = w_rf_ce;
  assign o_data_memory_read_enable = w_dm_rd_en;
  assign o_direct_load             = w_direct_load;
  assign o_busy   = (r_state == ST_FETCH) || (r_state == ST_DECODE) ||
                    (r_state == ST_MEM)   || (r_state == ST_EXEC);
  assign o_halted = (r_state == ST_HALT);

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port i_clk, input, 1, sole clock; all state changes on rising edge.
REQ-002 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port i_start, input, 1, begin execution from address 0 when in IDLE or HALT; ignored otherwise.
REQ-004 SHALL have port i_instr, input, 16, program memory read data, valid one cycle after o_instr_addr is presented.
REQ-005 SHALL have port i_acumulator, input, 8, accumulator value from the datapath, used by JZ.
REQ-006 SHALL have port o_instr_addr, output, 8, program counter driven to program memory.
REQ-007 SHALL have port o_data_memory_addr, output, 8, equal to IR[7:0].
REQ-008 SHALL have port o_operation_code, output, 3, ALU operation for the datapath.
REQ-009 SHALL have port o_acumulator_ce, output, 1, accumulator load enable.
REQ-010 SHALL have port o_register_file_ce, output, 3, where 3'b000-3'b011 writes register 0-3 and 3'b100 writes none.
REQ-011 SHALL have port o_register_file_mux_addr, output, 2, register file read select.
REQ-012 SHALL have port o_data_memory_read_enable, output, 1, selects data memory as the ALU operand.
REQ-013 SHALL have port o_direct_data, output, 8, immediate value equal to IR[7:0].
REQ-014 SHALL have port o_direct_load, output, 1, selects immediate load into the accumulator.
REQ-015 SHALL have port o_busy, output, 1, asserted in FETCH/DECODE/MEM/EXEC.
REQ-016 SHALL have port o_halted, output, 1, asserted in HALT.

Function
REQ-017 Instruction format SHALL be: [15:13] class, [12:10] ALU op, [9:8] register, [7:0] immediate/address.
REQ-018 Classes SHALL be: 000 NOP; 001 ALU_RF; 010 ALU_DM; 011 LDI; 100 ST; 101 JMP; 110 JZ; 111 HALT.
REQ-019 FSM states SHALL be IDLE, FETCH, DECODE, MEM, EXEC, HALT.
REQ-020 IDLE SHALL go to FETCH on i_start with PC=0.
REQ-021 FETCH SHALL go to DECODE unconditionally.
REQ-022 DECODE SHALL latch i_instr into IR and set PC=PC+1, wrapping mod 256 (255->0).
REQ-023 DECODE SHALL then go to MEM for ALU_DM and to EXEC for all other classes.
REQ-024 MEM SHALL go to EXEC unconditionally, covering the 1-cycle data memory read latency.
REQ-025 EXEC SHALL last exactly one cycle, then go to HALT for class HALT and to FETCH otherwise.
REQ-026 Instruction latency SHALL be 3 cycles, or 4 cycles for ALU_DM.
REQ-027 Outside EXEC the outputs SHALL be: acumulator_ce=0, direct_load=0, data_memory_read_enable=0, register_file_ce=3'b100, operation_code=3'b110 (LD).
REQ-028 o_register_file_mux_addr SHALL equal IR[9:8] in all states.
REQ-029 In EXEC, ALU_RF SHALL drive operation_code=IR[12:10] and acumulator_ce=1.
REQ-030 In EXEC, ALU_DM SHALL drive the same as ALU_RF plus data_memory_read_enable=1.
REQ-031 In EXEC, LDI SHALL drive acumulator_ce=1 and direct_load=1.
REQ-032 In EXEC, ST SHALL drive register_file_ce={1'b0,IR[9:8]}.
REQ-033 In EXEC, NOP and HALT SHALL drive no enables.
REQ-034 In EXEC, JMP SHALL set PC=IR[7:0], overriding the DECODE increment.
REQ-035 In EXEC, JZ SHALL set PC=IR[7:0] only if i_acumulator==8'h00 in that cycle; otherwise PC is unchanged.
REQ-036 HALT SHALL hold PC and all enables inactive.
REQ-037 i_start in HALT SHALL set PC=0 and go to FETCH.
REQ-038 Combinational outputs SHALL depend only on state, IR and PC (Moore).

Reset
REQ-039 Asserting i_rst_n low in any state, including mid-instruction, SHALL immediately force IDLE, PC=0, IR=16'h0000, and all outputs per REQ-027 with busy=0 and halted=0.
REQ-040 After i_rst_n deasserts, execution SHALL not begin until i_start is seen.

Structure
REQ-041 The shared package SHALL hold the FSM state enum, the instruction class enum, the RF_CE_NONE=3'b100 constant, and instruction field index constants; the existing ALU operation enum SHALL be reused from it.
REQ-042 Instruction field decoding SHALL be one combinational sub-module, cu_decoder (IR in, class/fields out); the FSM and PC stay in control_unit.

Verification
REQ-043 Reset, then i_start, with program {LDI 8'h05; ST r2; HALT}: o_acumulator_ce and o_direct_load high with o_direct_data=05 in cycle 3; o_register_file_ce=3'b010 in cycle 6; o_halted high from cycle 10.
REQ-044 Run ALU_DM ADD at address 8'h3C: MEM state seen, o_data_memory_addr=3C, then one EXEC cycle with read_enable=1 and operation_code=000; 4 cycles total.
REQ-045 Run JZ 8'h20 with i_acumulator=00 and then with 01: next o_instr_addr is 20 in the first case and PC+1 in the second.
REQ-046 Run JMP 8'hFF, where FF holds NOP: after that NOP, o_instr_addr wraps to 00.
REQ-047 Pull i_rst_n low during MEM: outputs reset asynchronously before the next clock edge; a following i_start refetches address 00.
REQ-048 Pulse i_start during EXEC: no effect. Pulse i_start in HALT: o_instr_addr=00, state FETCH.
